spi_adc_responder: RTL and testbench

Synthesizable SPI responder that emulates a serial ADC (16-bit frame: leading zeros then sample, MSB first) on the far side of the SPI ADC master. It oversamples the master's SCLK and CS_n with the system clock, shifts out the latched sample on MISO, and flags complete and aborted frames. It is used as the loop-back target in the SPI ADC IP bench and on-board self-test.

---
 rtl/spi_adc_responder.sv | 166 ++++++++++++++++
 tb/tb_spi_adc_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// spi_adc_responder
//
// Emulates a serial ADC on the far side of an SPI master. SCLK and CS_n are
// oversampled with clk_i. The latched sample goes out on MISO, MSB first,
// behind FrameBits-DataWidth leading zeros. Complete frames and aborted
// frames are flagged with one-cycle pulses.
//
// Ports
//   clk_i           system clock
//   rst_i           asynchronous reset, active-low
//   sample_i        sample value to transmit
//   sample_valid_i  loads sample_i into the holding register
//   sclk_i          SPI clock from the master (idle low, asynchronous)
//   cs_ni           chip select from the master (active-low, asynchronous)
//   miso_o          serial data to the master
//   miso_oe_o       MISO output enable, high while the frame is selected
//   busy_o          high in SHIFT and DONE
//   frame_done_o    one-cycle pulse when a full frame ends
//   frame_err_o     one-cycle pulse when CS_n deasserts mid-frame
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not selected, MISO released, waiting for CS_n falling edge
// SHIFT | selected, shifting one bit out per SCLK falling edge
// DONE  | all FrameBits shifted, MISO held low until CS_n rises

module spi_adc_responder #(
    parameter int DataWidth  = 12,
    parameter int FrameBits  = 16,
    parameter int SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] sample_i,
    input  logic                 sample_valid_i,
    input  logic                 sclk_i,
    input  logic                 cs_ni,
    output logic                 miso_o,
    output logic                 miso_oe_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 frame_err_o
);

    localparam int CntW = $clog2(FrameBits + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [SyncStages-1:0] r_sclk_sync;
    logic [SyncStages-1:0] r_cs_sync;
    logic                  r_sclk_d;
    logic                  r_cs_d;

    logic [DataWidth-1:0]  r_hold;
    logic [FrameBits-1:0]  r_shift;
    logic [CntW-1:0]       r_cnt;
    logic [1:0]            r_state;
    logic                  r_done_evt;
    logic                  r_err_evt;

    logic                  w_sclk;
    logic                  w_cs;
    logic                  w_sclk_fall;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic [DataWidth-1:0]  w_load_val;

    // Synchronizers reset to the idle pin levels so that releasing reset
    // never looks like an SCLK or CS_n edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SyncStages-2:0], sclk_i};
            r_cs_sync   <= {r_cs_sync[SyncStages-2:0], cs_ni};
            r_sclk_d    <= r_sclk_sync[SyncStages-1];
            r_cs_d      <= r_cs_sync[SyncStages-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SyncStages-1];
    assign w_cs        = r_cs_sync[SyncStages-1];
    assign w_sclk_fall = r_sclk_d & ~w_sclk;
    assign w_cs_fall   = r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;

    // A sample presented in the same cycle the frame starts is sent directly.
    assign w_load_val  = sample_valid_i ? sample_i : r_hold;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hold <= '0;
        end else if (sample_valid_i) begin
            r_hold <= sample_i;
        end
    end

    // CS_n edges take priority over SCLK edges in every state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_done_evt <= 1'b0;
            r_err_evt  <= 1'b0;
        end else begin
            r_done_evt <= 1'b0;
            r_err_evt  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_shift <= FrameBits'(w_load_val);
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        r_err_evt <= 1'b1;
                        r_shift   <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_sclk_fall) begin
                        r_shift <= {r_shift[FrameBits-2:0], 1'b0};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CntW'(FrameBits - 1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_cs_rise) begin
                        r_done_evt <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One output register stage behind the FSM keeps all pin-facing outputs
    // glitch-free and aligned at SyncStages+2 cycles after the pin edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            miso_o       <= 1'b0;
            miso_oe_o    <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            miso_o       <= (r_state == ST_SHIFT) & r_shift[FrameBits-1];
            miso_oe_o    <= (r_state != ST_IDLE);
            busy_o       <= (r_state != ST_IDLE);
            frame_done_o <= r_done_evt;
            frame_err_o  <= r_err_evt;
        end
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder
//
// Drives an SPI master model against spi_adc_responder. Each frame pushes
// its expected MISO capture onto a scoreboard queue; the captured word is
// popped and compared when the frame ends. Pulse counts come from a monitor.

module tb_spi_adc_responder;

    logic        clk_i;
    logic        rst_i;
    logic [11:0] sample_i;
    logic        sample_valid_i;
    logic        sclk_i;
    logic        cs_ni;
    logic        miso_o;
    logic        miso_oe_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        frame_err_o;

    int          n_checks;
    int          n_fail;
    int          done_cnt;
    int          err_cnt;
    logic [31:0] sb_q[$];

    spi_adc_responder #(
        .DataWidth (12),
        .FrameBits (16),
        .SyncStages(2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .sclk_i        (sclk_i),
        .cs_ni         (cs_ni),
        .miso_o        (miso_o),
        .miso_oe_o     (miso_oe_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .frame_err_o   (frame_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Counts high cycles, so a pulse that lasts two cycles counts twice.
    initial begin
        done_cnt = 0;
        err_cnt  = 0;
    end
    always @(negedge clk_i) begin
        if (frame_done_o) done_cnt = done_cnt + 1;
        if (frame_err_o)  err_cnt  = err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic load_hold(input logic [11:0] v);
        sample_i       = v;
        sample_valid_i = 1'b1;
        tick(1);
        sample_valid_i = 1'b0;
        tick(1);
    endtask

    // Expected bits captured on n rising edges: the 16-bit frame MSB first,
    // then zeros for any edges past the frame.
    function automatic logic [31:0] model_cap(input logic [15:0] w, input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            m = {m[30:0], (i < 16) ? w[15 - i] : 1'b0};
        end
        return m;
    endfunction

    task automatic run_frame(input string tag, input int n_edges, input bit byp,
                             input int mid_edge, input logic [11:0] val,
                             input bit chk_lat, input logic [15:0] exp_word);
        logic [31:0] cap;
        logic [31:0] exp_cap;
        int d0;
        int e0;
        sb_q.push_back(model_cap(exp_word, n_edges));
        d0  = done_cnt;
        e0  = err_cnt;
        cap = '0;
        cs_ni = 1'b0;
        if (chk_lat) begin
            tick(3);
            check_eq({tag, "_busy_pre"}, {31'b0, busy_o}, 32'd0);
            tick(1);
            check_eq({tag, "_busy_rise"}, {31'b0, busy_o}, 32'd1);
            tick(2);
        end else if (byp) begin
            tick(2);
            sample_i       = val;
            sample_valid_i = 1'b1;
            tick(1);
            sample_valid_i = 1'b0;
            tick(3);
        end else begin
            tick(6);
        end
        for (int i = 0; i < n_edges; i++) begin
            cap    = {cap[30:0], miso_o};
            sclk_i = 1'b1;
            tick(5);
            sclk_i = 1'b0;
            if (mid_edge == i + 1) begin
                sample_i       = val;
                sample_valid_i = 1'b1;
                tick(1);
                sample_valid_i = 1'b0;
                tick(4);
            end else begin
                tick(5);
            end
        end
        cs_ni = 1'b1;
        if (chk_lat) begin
            tick(3);
            check_eq({tag, "_busy_hold"}, {31'b0, busy_o}, 32'd1);
            tick(1);
            check_eq({tag, "_busy_fall"}, {31'b0, busy_o}, 32'd0);
            check_eq({tag, "_done_lat"}, {31'b0, frame_done_o}, 32'd1);
            tick(6);
        end else begin
            tick(10);
        end
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp_cap = sb_q.pop_front();
            check_eq({tag, "_data"}, cap, exp_cap);
        end
        check_eq({tag, "_done_cnt"}, done_cnt - d0, (n_edges >= 16) ? 32'd1 : 32'd0);
        check_eq({tag, "_err_cnt"}, err_cnt - e0, (n_edges >= 16) ? 32'd0 : 32'd1);
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq({tag, "_miso"}, {31'b0, miso_o}, 32'd0);
        check_eq({tag, "_oe"},   {31'b0, miso_oe_o}, 32'd0);
        check_eq({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        check_eq({tag, "_done"}, {31'b0, frame_done_o}, 32'd0);
        check_eq({tag, "_err"},  {31'b0, frame_err_o}, 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        n_checks       = 0;
        n_fail         = 0;
        rst_i          = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        sclk_i         = 1'b0;
        cs_ni          = 1'b1;
        tick(3);
        check_outs_zero("rst_hold");
        rst_i = 1'b1;
        tick(5);
        check_outs_zero("rst_rel");

        // Hold is still 0 after reset; the sample arrives in the detect cycle.
        run_frame("bypass", 16, 1'b1, 0, 12'h555, 1'b0, 16'h0555);

        load_hold(12'hABC);
        run_frame("nominal", 16, 1'b0, 0, 12'h000, 1'b1, 16'h0ABC);

        load_hold(12'h123);
        run_frame("midload", 16, 1'b0, 5, 12'hFFF, 1'b0, 16'h0123);
        run_frame("after_mid", 16, 1'b0, 0, 12'h000, 1'b0, 16'h0FFF);

        run_frame("abort", 9, 1'b0, 0, 12'h000, 1'b0, 16'h0FFF);
        run_frame("after_abort", 16, 1'b0, 0, 12'h000, 1'b0, 16'h0FFF);

        load_hold(12'hABC);
        run_frame("overrun", 20, 1'b0, 0, 12'h000, 1'b0, 16'h0ABC);

        // Reset in the middle of a frame, after 7 SCLK edges.
        d0    = done_cnt;
        e0    = err_cnt;
        cs_ni = 1'b0;
        tick(6);
        for (int i = 0; i < 7; i++) begin
            sclk_i = 1'b1;
            tick(5);
            sclk_i = 1'b0;
            tick(5);
        end
        check_eq("midrst_oe_before", {31'b0, miso_oe_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check_outs_zero("midrst");
        tick(2);
        cs_ni = 1'b1;
        tick(2);
        rst_i = 1'b1;
        tick(12);
        check_eq("midrst_done_cnt", done_cnt - d0, 32'd0);
        check_eq("midrst_err_cnt", err_cnt - e0, 32'd0);
        check_eq("midrst_busy_after", {31'b0, busy_o}, 32'd0);
        check_eq("midrst_oe_after", {31'b0, miso_oe_o}, 32'd0);

        // The hold register was cleared by reset.
        run_frame("post_rst", 16, 1'b0, 0, 12'h000, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
